// File: rtl/dpram_arb_pkg.sv
// Shared types, limits and the hazard predicate for the dual-port RAM front-end arbiter.
package dpram_arb_pkg;

    localparam int MAX_READ_LATENCY = 4;
    localparam int REQ_ADDR_WIDTH   = 4;
    localparam int REQ_DATA_WIDTH   = 8;

    // Command bundle at the default RAM geometry.
    typedef struct packed {
        logic                      we;
        logic [REQ_ADDR_WIDTH-1:0] addr;
        logic [REQ_DATA_WIDTH-1:0] wdata;
    } req_t;

    // Same-address access where at least one side writes; read-read is harmless.
    function automatic logic addr_conflict(
        input logic valid0,
        input logic valid1,
        input logic we0,
        input logic we1,
        input logic same_addr
    );
        return valid0 & valid1 & same_addr & (we0 | we1);
    endfunction

endpackage

// File: rtl/dpram_rd_tracker.sv
// Read-latency shift register: one flag per accepted read, emerging READ_LATENCY cycles later.
module dpram_rd_tracker
    import dpram_arb_pkg::*;
#(
    parameter int READ_LATENCY = 1
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_load,
    output logic o_valid
);

    // Out-of-range latencies are clamped into the supported 1..MAX window.
    localparam int DEPTH = (READ_LATENCY < 1) ? 1 :
                           (READ_LATENCY > MAX_READ_LATENCY) ? MAX_READ_LATENCY : READ_LATENCY;

    logic [DEPTH-1:0] rd_pipe;

    generate
        if (DEPTH == 1) begin : g_single
            always_ff @(posedge i_clk) begin
                if (!i_rst_n) rd_pipe <= '0;
                else          rd_pipe <= i_load;
            end
        end else begin : g_shift
            always_ff @(posedge i_clk) begin
                if (!i_rst_n) rd_pipe <= '0;
                else          rd_pipe <= {rd_pipe[DEPTH-2:0], i_load};
            end
        end
    endgenerate

    assign o_valid = rd_pipe[DEPTH-1];

endmodule

// File: rtl/dpram_port_arbiter.sv
// Maps two requesters onto the two RAM ports, serialising same-address write hazards round-robin.
module dpram_port_arbiter
    import dpram_arb_pkg::*;
#(
    parameter int ADDR_WIDTH   = 4,
    parameter int DATA_WIDTH   = 8,
    parameter int READ_LATENCY = 1,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_req0_valid,
    output logic                  o_req0_ready,
    input  logic                  i_req0_we,
    input  logic [ADDR_WIDTH-1:0] i_req0_addr,
    input  logic [DATA_WIDTH-1:0] i_req0_wdata,
    output logic                  o_rsp0_valid,
    output logic [DATA_WIDTH-1:0] o_rsp0_rdata,
    input  logic                  i_req1_valid,
    output logic                  o_req1_ready,
    input  logic                  i_req1_we,
    input  logic [ADDR_WIDTH-1:0] i_req1_addr,
    input  logic [DATA_WIDTH-1:0] i_req1_wdata,
    output logic                  o_rsp1_valid,
    output logic [DATA_WIDTH-1:0] o_rsp1_rdata,
    output logic                  o_ram_ena,
    output logic                  o_ram_wea,
    output logic [ADDR_WIDTH-1:0] o_ram_addra,
    output logic [DATA_WIDTH-1:0] o_ram_dina,
    input  logic [DATA_WIDTH-1:0] i_ram_douta,
    output logic                  o_ram_enb,
    output logic                  o_ram_web,
    output logic [ADDR_WIDTH-1:0] o_ram_addrb,
    output logic [DATA_WIDTH-1:0] o_ram_dinb,
    input  logic [DATA_WIDTH-1:0] i_ram_doutb,
    output logic [CNT_WIDTH-1:0]  o_conflict_cnt
);

    // Handshake: a command transfers in any cycle where valid and ready are both high;
    // ready depends only on this cycle's inputs and rr, and responses have no backpressure.
    logic                 rr;
    logic                 conflict;
    logic                 accept0;
    logic                 accept1;
    logic [CNT_WIDTH-1:0] conflict_cnt;

    always_comb begin
        conflict     = addr_conflict(i_req0_valid, i_req1_valid, i_req0_we, i_req1_we,
                                     i_req0_addr == i_req1_addr);
        o_req0_ready = i_rst_n & (~conflict | ~rr);
        o_req1_ready = i_rst_n & (~conflict | rr);
        accept0      = i_req0_valid & o_req0_ready;
        accept1      = i_req1_valid & o_req1_ready;
    end

    assign o_ram_ena   = accept0;
    assign o_ram_wea   = accept0 & i_req0_we;
    assign o_ram_addra = i_req0_addr;
    assign o_ram_dina  = i_req0_wdata;
    assign o_ram_enb   = accept1;
    assign o_ram_web   = accept1 & i_req1_we;
    assign o_ram_addrb = i_req1_addr;
    assign o_ram_dinb  = i_req1_wdata;

    // The winner of a conflict is rr, so toggling hands priority to the loser.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            rr           <= 1'b0;
            conflict_cnt <= '0;
        end else if (conflict) begin
            rr <= ~rr;
            if (conflict_cnt != '1) conflict_cnt <= conflict_cnt + CNT_WIDTH'(1);
        end
    end

    assign o_conflict_cnt = conflict_cnt;

    dpram_rd_tracker #(.READ_LATENCY(READ_LATENCY)) u_trk0 (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_load  (accept0 & ~i_req0_we),
        .o_valid (o_rsp0_valid)
    );

    dpram_rd_tracker #(.READ_LATENCY(READ_LATENCY)) u_trk1 (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_load  (accept1 & ~i_req1_we),
        .o_valid (o_rsp1_valid)
    );

    assign o_rsp0_rdata = i_ram_douta;
    assign o_rsp1_rdata = i_ram_doutb;

endmodule

// File: tb/tb_dpram_port_arbiter.sv
// Directed bench: default-geometry arbiter with a RAM model, plus a latency-3 / 4-bit-counter instance.
module tb_dpram_port_arbiter;
    import dpram_arb_pkg::*;

    logic clk;
    int   vectors = 0;
    int   errs    = 0;

    // ---------------- main instance (READ_LATENCY = 1, CNT_WIDTH = 16) ----------------
    logic        rst_n;
    logic        v0, v1;
    req_t        r0, r1;
    logic        rdy0, rdy1, rv0, rv1;
    logic [7:0]  rd0, rd1;
    logic        ena, wea, enb, web;
    logic [3:0]  addra, addrb;
    logic [7:0]  dina, dinb, douta, doutb;
    logic [15:0] cnt;
    logic [7:0]  mem [16];

    dpram_port_arbiter dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_req0_valid(v0), .o_req0_ready(rdy0), .i_req0_we(r0.we),
        .i_req0_addr(r0.addr), .i_req0_wdata(r0.wdata),
        .o_rsp0_valid(rv0), .o_rsp0_rdata(rd0),
        .i_req1_valid(v1), .o_req1_ready(rdy1), .i_req1_we(r1.we),
        .i_req1_addr(r1.addr), .i_req1_wdata(r1.wdata),
        .o_rsp1_valid(rv1), .o_rsp1_rdata(rd1),
        .o_ram_ena(ena), .o_ram_wea(wea), .o_ram_addra(addra), .o_ram_dina(dina),
        .i_ram_douta(douta),
        .o_ram_enb(enb), .o_ram_web(web), .o_ram_addrb(addrb), .o_ram_dinb(dinb),
        .i_ram_doutb(doutb),
        .o_conflict_cnt(cnt)
    );

    // Read-first dual-port RAM, one cycle of read latency, known contents after reset.
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < 16; k++) mem[k] <= 8'(8'h30 + k);
        end else begin
            if (ena) begin
                if (wea) mem[addra] <= dina;
                douta <= mem[addra];
            end
            if (enb) begin
                if (web) mem[addrb] <= dinb;
                doutb <= mem[addrb];
            end
        end
    end

    // ---------------- second instance (READ_LATENCY = 3, CNT_WIDTH = 4) ----------------
    logic       b_rst_n;
    logic       b_v0, b_v1, b_we0, b_we1;
    logic [3:0] b_a0, b_a1;
    logic [7:0] b_d0, b_d1;
    logic       b_rdy0, b_rdy1, b_rv0, b_rv1;
    logic [7:0] b_rd0, b_rd1;
    logic       b_ena, b_wea, b_enb, b_web;
    logic [3:0] b_addra, b_addrb;
    logic [7:0] b_dina, b_dinb;
    logic [7:0] b_douta = 8'h00;
    logic [7:0] b_doutb = 8'h00;
    logic [3:0] b_cnt;

    dpram_port_arbiter #(.READ_LATENCY(3), .CNT_WIDTH(4)) dut3 (
        .i_clk(clk), .i_rst_n(b_rst_n),
        .i_req0_valid(b_v0), .o_req0_ready(b_rdy0), .i_req0_we(b_we0),
        .i_req0_addr(b_a0), .i_req0_wdata(b_d0),
        .o_rsp0_valid(b_rv0), .o_rsp0_rdata(b_rd0),
        .i_req1_valid(b_v1), .o_req1_ready(b_rdy1), .i_req1_we(b_we1),
        .i_req1_addr(b_a1), .i_req1_wdata(b_d1),
        .o_rsp1_valid(b_rv1), .o_rsp1_rdata(b_rd1),
        .o_ram_ena(b_ena), .o_ram_wea(b_wea), .o_ram_addra(b_addra), .o_ram_dina(b_dina),
        .i_ram_douta(b_douta),
        .o_ram_enb(b_enb), .o_ram_web(b_web), .o_ram_addrb(b_addrb), .o_ram_dinb(b_dinb),
        .i_ram_doutb(b_doutb),
        .o_conflict_cnt(b_cnt)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance past one rising edge and land mid-cycle, away from the edge.
    task automatic tick;
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        // 1: reset held with a pending write conflict on both instances
        rst_n = 1'b0; b_rst_n = 1'b0;
        v0 = 1'b1; v1 = 1'b1;
        r0 = '{we: 1'b1, addr: 4'd1, wdata: 8'h01};
        r1 = '{we: 1'b1, addr: 4'd1, wdata: 8'h02};
        b_v0 = 1'b1; b_v1 = 1'b1; b_we0 = 1'b1; b_we1 = 1'b1;
        b_a0 = 4'd0; b_a1 = 4'd0; b_d0 = 8'h00; b_d1 = 8'h00;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_rdy0", rdy0, 0);
            chk("rst_rdy1", rdy1, 0);
            chk("rst_ena", ena, 0);
            chk("rst_enb", enb, 0);
            chk("rst_cnt", cnt, 0);
            chk("rst_rsp", {rv1, rv0}, 0);
        end
        chk("rst_b_rdy", {b_rdy1, b_rdy0}, 0);
        chk("rst_b_cnt", b_cnt, 0);
        rst_n = 1'b1; b_rst_n = 1'b1;
        v0 = 1'b0; v1 = 1'b0; b_v0 = 1'b0; b_v1 = 1'b0;
        tick();

        // 2: parallel writes to different addresses, then swapped reads
        v0 = 1'b1; r0 = '{we: 1'b1, addr: 4'd3, wdata: 8'hA5};
        v1 = 1'b1; r1 = '{we: 1'b1, addr: 4'd7, wdata: 8'h5A};
        #1;
        chk("par_wr_rdy", {rdy1, rdy0}, 2'b11);
        chk("par_wr_en", {enb, web, ena, wea}, 4'b1111);
        chk("par_wr_addr", {addrb, addra}, 8'h73);
        tick();
        r0 = '{we: 1'b0, addr: 4'd7, wdata: 8'h00};
        r1 = '{we: 1'b0, addr: 4'd3, wdata: 8'h00};
        #1;
        chk("par_rd_rdy", {rdy1, rdy0}, 2'b11);
        chk("par_rd_we", {web, wea}, 2'b00);
        chk("par_rd_early", {rv1, rv0}, 2'b00);
        tick();
        v0 = 1'b0; v1 = 1'b0;
        chk("par_rsp_valid", {rv1, rv0}, 2'b11);
        chk("par_rsp0", rd0, 8'h5A);
        chk("par_rsp1", rd1, 8'hA5);
        chk("par_cnt", cnt, 0);
        tick();
        chk("par_rsp_once", {rv1, rv0}, 2'b00);

        // 3: write-write conflict at address 5
        v0 = 1'b1; r0 = '{we: 1'b1, addr: 4'd5, wdata: 8'h11};
        v1 = 1'b1; r1 = '{we: 1'b1, addr: 4'd5, wdata: 8'h22};
        #1;
        chk("ww_c0_rdy", {rdy1, rdy0}, 2'b01);
        chk("ww_c0_en", {enb, ena}, 2'b01);
        tick();
        v0 = 1'b0;
        #1;
        chk("ww_c1_rdy1", rdy1, 1);
        chk("ww_c1_enb", {enb, web}, 2'b11);
        chk("ww_cnt", cnt, 1);
        tick();
        v1 = 1'b0;
        v0 = 1'b1; r0 = '{we: 1'b0, addr: 4'd5, wdata: 8'h00};
        tick();
        v0 = 1'b0;
        chk("ww_rd_valid", rv0, 1);
        chk("ww_rd_data", rd0, 8'h22);
        chk("ww_cnt_after", cnt, 1);

        // 4: fairness under six back-to-back conflicts, from a fresh rr
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            v0 = 1'b1; r0 = '{we: 1'b1, addr: 4'd9, wdata: 8'(8'h40 + i)};
            v1 = 1'b1; r1 = '{we: 1'b1, addr: 4'd9, wdata: 8'(8'h50 + i)};
            #1;
            chk("fair_rdy", {rdy1, rdy0}, (i % 2 == 0) ? 2'b01 : 2'b10);
            tick();
        end
        v0 = 1'b0; v1 = 1'b0;
        chk("fair_cnt", cnt, 6);

        // 5a: read-read to one address is not a conflict
        v0 = 1'b1; r0 = '{we: 1'b0, addr: 4'd2, wdata: 8'h00};
        v1 = 1'b1; r1 = '{we: 1'b0, addr: 4'd2, wdata: 8'h00};
        #1;
        chk("rr_rdy", {rdy1, rdy0}, 2'b11);
        tick();
        v0 = 1'b0; v1 = 1'b0;
        chk("rr_valid", {rv1, rv0}, 2'b11);
        chk("rr_data0", rd0, 8'h32);
        chk("rr_data1", rd1, 8'h32);
        chk("rr_cnt", cnt, 6);

        // 5b: read against write at one address is a conflict; requester 0 holds priority
        v0 = 1'b1; r0 = '{we: 1'b0, addr: 4'd4, wdata: 8'h00};
        v1 = 1'b1; r1 = '{we: 1'b1, addr: 4'd4, wdata: 8'h77};
        #1;
        chk("rw_rdy", {rdy1, rdy0}, 2'b01);
        tick();
        v0 = 1'b0;
        #1;
        chk("rw_rdy1", rdy1, 1);
        chk("rw_cnt", cnt, 7);
        chk("rw_old_data", {7'd0, rv0, rd0}, {7'd0, 1'b1, 8'h34});
        tick();
        v1 = 1'b0;
        v0 = 1'b1; r0 = '{we: 1'b0, addr: 4'd4, wdata: 8'h00};
        tick();
        v0 = 1'b0;
        chk("rw_new_data", {7'd0, rv0, rd0}, {7'd0, 1'b1, 8'h77});

        // 6a: latency-3 read strobe timing
        b_v0 = 1'b1; b_we0 = 1'b0; b_a0 = 4'd1;
        #1;
        chk("l3_rdy", b_rdy0, 1);
        tick();
        b_v0 = 1'b0;
        chk("l3_c1", b_rv0, 0);
        tick();
        chk("l3_c2", b_rv0, 0);
        tick();
        chk("l3_c3", b_rv0, 1);
        tick();
        chk("l3_c4", b_rv0, 0);

        // 6b: reset one cycle after an accepted read drops it
        b_v0 = 1'b1; b_we0 = 1'b0; b_a0 = 4'd2;
        tick();
        b_v0 = 1'b0;
        tick();
        b_rst_n = 1'b0;
        tick();
        b_rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            chk("rst_drop", b_rv0, 0);
            tick();
        end

        // 6c: 4-bit counter saturates after 18 conflicts
        b_v0 = 1'b1; b_v1 = 1'b1; b_we0 = 1'b1; b_we1 = 1'b1;
        b_a0 = 4'd0; b_a1 = 4'd0;
        for (int n = 1; n <= 18; n++) begin
            tick();
            if (n == 14) chk("sat_14", b_cnt, 4'hE);
            if (n == 15) chk("sat_15", b_cnt, 4'hF);
        end
        b_v0 = 1'b0; b_v1 = 1'b0;
        chk("sat_18", b_cnt, 4'hF);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule

// File: doc/dpram_port_arbiter.md
Name: dpram_port_arbiter

Overview:
Front-end controller for the two-port RAM block. It takes two independent requesters with valid/ready handshakes and maps requester 0 onto RAM port A and requester 1 onto RAM port B. It detects same-address hazards where at least one side writes, and serialises them with round-robin fairness. It also tracks read latency, so each requester gets a qualified read-data strobe.

Parameters:
ADDR_WIDTH, 4, RAM address width; must match the RAM instance.
DATA_WIDTH, 8, RAM data width; must match the RAM instance.
READ_LATENCY, 1, cycles from an accepted read to valid RAM output data; legal range 1..4.
CNT_WIDTH, 16, width of the conflict counter.

Ports:
i_clk  in  1  single clock for arbiter and both RAM ports
i_rst_n  in  1  synchronous active-low reset
i_req0_valid  in  1  requester 0 command valid
o_req0_ready  out  1  requester 0 command accepted this cycle when valid
i_req0_we  in  1  1 = write, 0 = read
i_req0_addr  in  ADDR_WIDTH  requester 0 address
i_req0_wdata  in  DATA_WIDTH  requester 0 write data
o_rsp0_valid  out  1  requester 0 read data valid
o_rsp0_rdata  out  DATA_WIDTH  requester 0 read data
i_req1_valid / o_req1_ready / i_req1_we / i_req1_addr / i_req1_wdata  same as requester 0, for requester 1
o_rsp1_valid / o_rsp1_rdata  same as requester 0, for requester 1
o_ram_ena  out  1  RAM port A enable
o_ram_wea  out  1  RAM port A write enable
o_ram_addra  out  ADDR_WIDTH  RAM port A address
o_ram_dina  out  DATA_WIDTH  RAM port A write data
i_ram_douta  in  DATA_WIDTH  RAM port A read data
o_ram_enb / o_ram_web / o_ram_addrb / o_ram_dinb / i_ram_doutb  same as port A, for port B
o_conflict_cnt  out  CNT_WIDTH  saturating count of conflict cycles

Behaviour:
- Conflict definition: conflict = i_req0_valid & i_req1_valid & (i_req0_addr == i_req1_addr) & (i_req0_we | i_req1_we).
  - Read-read to the same address is not a conflict.
  - Different addresses are never a conflict.
- Ready (combinational from inputs and the rr register):
  - No conflict: o_req0_ready = o_req1_ready = 1 (outside reset).
  - Conflict: only the rr winner is ready; the loser holds ready = 0.
- Round-robin register rr, where 0 means requester 0 has priority.
  - Reset value 0.
  - On a conflict cycle, rr <= index of the loser, so the loser wins the next conflict.
  - rr is unchanged on non-conflict cycles.
  - Guarantees each requester waits at most one consecutive conflict cycle.
- Accept: accept_n = i_reqn_valid & o_reqn_ready.
- RAM drive (combinational, zero added latency):
  - o_ram_ena = accept0; o_ram_wea = accept0 & i_req0_we.
  - o_ram_addra = i_req0_addr; o_ram_dina = i_req0_wdata.
  - Port B is identical, driven from requester 1.
  - The RAM never sees two same-cycle same-address accesses that include a write.
- Read tracking: per-port shift register rd_pipe_n[READ_LATENCY-1:0].
  - Stage 0 loads accept_n & ~i_reqn_we; the register shifts every cycle.
  - o_rspn_valid = rd_pipe_n[READ_LATENCY-1].
  - o_rspn_rdata = i_ram_doutn passthrough, meaningful only when o_rspn_valid = 1.
  - Back-to-back reads give back-to-back strobes, one per read, in order.
  - There is no backpressure on responses; requesters must sink them.
- Conflict counter: increments by 1 on each conflict cycle and saturates at all-ones.
- Reset (i_rst_n = 0 at a clock edge):
  - rr = 0, rd_pipe_0 = rd_pipe_1 = 0, o_conflict_cnt = 0.
  - While i_rst_n = 0, both readies and all RAM enables/write enables are forced to 0.
  - Reads in flight when reset asserts are dropped: no rsp_valid after reset.
- Same-cycle write then read to one address in different cycles: ordering is the RAM's (write completes before a later accepted read). The arbiter adds no reordering.

Decomposition:
- Package dpram_arb_pkg:
  - Typedef req_t {we, addr, wdata}.
  - localparam MAX_READ_LATENCY = 4.
  - Function addr_conflict().
- One sub-module: dpram_rd_tracker, the parameterised READ_LATENCY shift register, instantiated once per port.

Test Plan:
1. Reset: hold i_rst_n = 0 for 3 cycles with both valids = 1 -> readies = 0, o_ram_ena/enb = 0, o_conflict_cnt = 0, no rsp_valid.
2. Parallel, no conflict: req0 write addr 3 data 0xA5 and req1 write addr 7 data 0x5A in the same cycle; then both read swapped addresses -> both ready every cycle; o_rsp0_rdata = 0x5A and o_rsp1_rdata = 0xA5 exactly READ_LATENCY cycles after the reads.
3. Write-write conflict at addr 5, req0 = 0x11, req1 = 0x22, both held valid -> cycle 0: req0 accepted, req1 stalled; cycle 1: req1 accepted; reading addr 5 then returns 0x22; o_conflict_cnt = 1.
4. Fairness: both requesters keep issuing writes to addr 9 for 6 cycles -> grants alternate 0, 1, 0, 1, 0, 1; o_conflict_cnt = 6 (for the 3-per-requester issue count, repeated conflicts); no requester waits more than 1 cycle.
5. Read-read same address 2 on both ports -> no stall; both rsp_valid in the same cycle with identical data; counter unchanged.
6. Reset mid-read: accept a read with READ_LATENCY = 3, assert reset 1 cycle later -> no rsp_valid is ever produced for that read. Also force 2^CNT_WIDTH+2 conflicts with CNT_WIDTH = 4 -> o_conflict_cnt saturates at 0xF.
